clarke_pipe: RTL

//  Parametrised, pipelined Clarke (abc -> alpha/beta) transform for the FOC current path.

---
 rtl/clarke_pkg.sv | 22 ++
 rtl/clarke_pipe_sat_round.sv | 37 +++
 rtl/clarke_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/clarke_pkg.sv
// Shared constants and types for the pipelined Clarke transform.
// The coefficients are defined for an 18-bit (Q0.17) coefficient path.
package clarke_pkg;

  localparam int CW_DEF = 18;

  localparam logic [CW_DEF-1:0] INV_SQRT3 = 18'd75674;   // round(2^17/sqrt(3))
  localparam logic [CW_DEF-1:0] ONE_THIRD = 18'd43691;   // round(2^17/3)
  localparam logic [CW_DEF-1:0] UNITY     = 18'd131072;  // 2^17, exact pass-through

  typedef enum logic {
    MODE_TWO_SENSOR   = 1'b0,
    MODE_THREE_SENSOR = 1'b1
  } mode_e;

  // Re-express a Q0.17 constant at another coefficient width, rounding when narrowing.
  function automatic logic [63:0] rescale(input logic [CW_DEF-1:0] c, input int cw);
    if (cw >= CW_DEF) return 64'(c) << (cw - CW_DEF);
    return (64'(c) + (64'd1 << (CW_DEF - cw - 1))) >> (CW_DEF - cw);
  endfunction

endpackage

// File: rtl/clarke_pipe_sat_round.sv
// Round-half-up arithmetic right shift followed by saturation to a narrower signed width.
// Reports whether the result had to be clipped.
module sat_round #(
  parameter int IW = 52,
  parameter int OW = 32,
  parameter int SH = 17
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  // One guard bit so the rounding offset can never wrap the operand.
  localparam int MW = IW + 1;
  localparam logic signed [MW-1:0] HALF    = MW'(64'd1 << (SH - 1));
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [MW-1:0] biased;
  logic signed [MW-1:0] shifted;

  // NOTE: every output is given a default at the top of the block so no latch is inferred.
  always_comb begin
    biased  = MW'(din) + HALF;
    shifted = biased >>> SH;
    dout    = shifted[OW-1:0];
    clip    = 1'b0;
    if (shifted > SAT_MAX) begin
      dout = SAT_MAX[OW-1:0];
      clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dout = SAT_MIN[OW-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/clarke_pipe.sv
// Three-stage Clarke (abc -> alpha/beta) transform with valid/ready handshake,
// per-sample two/three-sensor mode, round-half-up, saturation and sticky clip flag.
module clarke_pipe
  import clarke_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic signed [W-1:0] ia,
  input  logic signed [W-1:0] ib,
  input  logic signed [W-1:0] ic,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] ialp,
  output logic signed [W-1:0] ibet,
  output logic                sat_flag,
  input  logic                sat_clr
);

  localparam int SW = W + 2;   // sum width: 2ia-ib-ic cannot overflow here
  localparam int PW = SW + CW; // product width

  localparam logic [CW-1:0] K_SQRT3 = CW'(rescale(INV_SQRT3, CW));
  localparam logic [CW-1:0] K_THIRD = CW'(rescale(ONE_THIRD, CW));
  localparam logic [CW-1:0] K_UNITY = CW'(64'd1 << (CW - 1));

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: sums
  logic signed [SW-1:0] a_ext, b_ext, c_ext, sum_a, sum_b;
  logic                 s1_valid;
  mode_e                s1_mode;
  logic signed [SW-1:0] s1_sum_a, s1_sum_b;

  always_comb begin
    a_ext = SW'(ia);
    b_ext = SW'(ib);
    c_ext = SW'(ic);
    if (mode_e'(mode) == MODE_THREE_SENSOR) begin
      sum_a = (a_ext <<< 1) - b_ext - c_ext;
      sum_b = b_ext - c_ext;
    end else begin
      sum_a = a_ext;
      sum_b = a_ext + (b_ext <<< 1);
    end
  end

  // Stage 2: products; the unsigned coefficient gets a zero sign bit before the signed multiply.
  logic [CW-1:0]        coeff_a;
  logic signed [PW-1:0] prod_a, prod_b;
  logic                 s2_valid;
  logic signed [PW-1:0] s2_prod_a, s2_prod_b;

  always_comb begin
    coeff_a = (s1_mode == MODE_THREE_SENSOR) ? K_THIRD : K_UNITY;
    prod_a  = PW'(s1_sum_a) * $signed(PW'(coeff_a));
    prod_b  = PW'(s1_sum_b) * $signed(PW'(K_SQRT3));
  end

  // Stage 3: round, saturate
  logic signed [W-1:0] alp_sat, bet_sat;
  logic                clip_a, clip_b;

  sat_round #(.IW(PW), .OW(W), .SH(CW - 1)) u_round_alpha (
    .din  (s2_prod_a),
    .dout (alp_sat),
    .clip (clip_a)
  );

  sat_round #(.IW(PW), .OW(W), .SH(CW - 1)) u_round_beta (
    .din  (s2_prod_b),
    .dout (bet_sat),
    .clip (clip_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_TWO_SENSOR;
      s1_sum_a  <= '0;
      s1_sum_b  <= '0;
      s2_valid  <= 1'b0;
      s2_prod_a <= '0;
      s2_prod_b <= '0;
      out_valid <= 1'b0;
      ialp      <= '0;
      ibet      <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      // Data only loads behind a valid beat; bubbles leave it untouched.
      if (in_valid) begin
        s1_mode  <= mode_e'(mode);
        s1_sum_a <= sum_a;
        s1_sum_b <= sum_b;
      end
      if (s1_valid) begin
        s2_prod_a <= prod_a;
        s2_prod_b <= prod_b;
      end
      if (s2_valid) begin
        ialp <= alp_sat;
        ibet <= bet_sat;
      end
    end
  end

  // A clip landing in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (en && s2_valid && (clip_a || clip_b)) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule
